// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: simple dual-port RAM with byte-lane writes, write-first forwarding, 1/2-cycle read latency and post-reset clear
// Ports: CLK clock, RST_N async active-low reset,
//        EN_WR/BE_WR/ADDR_WR/D_IN write port with byte-lane enables,
//        EN_RD/ADDR_RD read request, D_OUT/VALID_OUT registered read result and strobe,
//        BUSY high while the array is being zeroed after reset.
// Optional: define DUAL_PORT_RAM_PARITY_EN to store even parity per byte lane and add the PAR_ERR output.
module dual_port_ram_be #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int DEPTH        = 16,
   parameter int RD_LATENCY   = 1,
   parameter int CLR_ON_RESET = 1,
   localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  EN_WR,
   input  logic [BE_WIDTH-1:0]   BE_WR,
   input  logic [ADDR_WIDTH-1:0] ADDR_WR,
   input  logic [DATA_WIDTH-1:0] D_IN,
   input  logic                  EN_RD,
   input  logic [ADDR_WIDTH-1:0] ADDR_RD,
   output logic [DATA_WIDTH-1:0] D_OUT,
   output logic                  VALID_OUT,
   output logic                  BUSY
`ifdef DUAL_PORT_RAM_PARITY_EN
   ,
   output logic                  PAR_ERR
`endif
);
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8");
   end
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("RD_LATENCY must be 1 or 2");
   end
   if (DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
      $error("DEPTH must not exceed 2**ADDR_WIDTH");
   end
   typedef enum logic {CLEAR, READY} state_t;
   state_t                  state;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word, s1_data;
   logic                    wr_ok, rd_ok, fwd, s1_vld;
`ifdef DUAL_PORT_RAM_PARITY_EN
   logic [BE_WIDTH-1:0]     par [DEPTH];
   logic [BE_WIDTH-1:0]     rd_par;
   logic                    rd_err, s1_err;
`endif
   // RST_N gating keeps the array untouched while reset is held, even when no clear is configured
   assign wr_ok = RST_N && state == READY && EN_WR && 32'(ADDR_WR) < DEPTH;
   assign rd_ok = state == READY && EN_RD;
   assign fwd   = wr_ok && ADDR_WR == ADDR_RD;
   assign BUSY  = state == CLEAR;
   always_ff @(posedge CLK) begin
      if (RST_N && state == CLEAR) begin
         mem[cnt] <= '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
         par[cnt] <= '0;
`endif
      end else if (wr_ok) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (BE_WR[i]) begin
               mem[ADDR_WR][8*i +: 8] <= D_IN[8*i +: 8];
`ifdef DUAL_PORT_RAM_PARITY_EN
               par[ADDR_WR][i] <= ^D_IN[8*i +: 8];
`endif
            end
         end
      end
   end
   // Write-first: enabled lanes of a same-address write replace the stored bytes on the read path
   always_comb begin
      rd_word = 32'(ADDR_RD) < DEPTH ? mem[ADDR_RD] : '0;
`ifdef DUAL_PORT_RAM_PARITY_EN
      rd_par = 32'(ADDR_RD) < DEPTH ? par[ADDR_RD] : '0;
      rd_err = 1'b0;
`endif
      for (int i = 0; i < BE_WIDTH; i++) begin
         rd_word[8*i +: 8] = fwd && BE_WR[i] ? D_IN[8*i +: 8] : rd_word[8*i +: 8];
`ifdef DUAL_PORT_RAM_PARITY_EN
         rd_par[i] = fwd && BE_WR[i] ? ^D_IN[8*i +: 8] : rd_par[i];
         rd_err    = rd_err | (^rd_word[8*i +: 8] ^ rd_par[i]);
`endif
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= CLR_ON_RESET != 0 ? CLEAR : READY;
         cnt       <= '0;
         D_OUT     <= '0;
         VALID_OUT <= 1'b0;
         s1_data   <= '0;
         s1_vld    <= 1'b0;
`ifdef DUAL_PORT_RAM_PARITY_EN
         s1_err    <= 1'b0;
         PAR_ERR   <= 1'b0;
`endif
      end else begin
         if (state == CLEAR) begin
            cnt   <= cnt + 1'b1;
            state <= 32'(cnt) == DEPTH - 1 ? READY : CLEAR;
         end
         s1_data <= rd_word;
         s1_vld  <= rd_ok;
`ifdef DUAL_PORT_RAM_PARITY_EN
         s1_err  <= rd_ok && rd_err;
         PAR_ERR <= RD_LATENCY == 1 ? rd_ok && rd_err : s1_err;
`endif
         if (RD_LATENCY == 1) begin
            VALID_OUT <= rd_ok;
            if (rd_ok) D_OUT <= rd_word;
         end else begin
            VALID_OUT <= s1_vld;
            if (s1_vld) D_OUT <= s1_data;
         end
      end
   end
endmodule
